id_ex_operand_stage: RTL

ID/EX pipeline stage that registers decoded operands and control, then produces the forwarded `SrcA`/`SrcB`/`Operation` that drive the EX-stage ALU. It sits directly upstream of the ALU. It also handles:
- EX/MEM and MEM/WB result forwarding,
- same-cycle writeback bypass at capture,
- load-use hazard detection with bubble insertion,
- stall/flush from the hazard and branch logic.

---
 rtl/pipeline_pkg.sv | 57 +++++
 rtl/forward_unit.sv | 31 +++
 rtl/id_ex_operand_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX operand stage: ALU codes, forwarding selects and the
// registered ID/EX record, plus the per-source forwarding priority rule.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 4;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [OPC_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_ADD = 4'b0100,
        ALU_SUB = 4'b0101,
        ALU_EQ  = 4'b1000
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic              alusrc;
        alu_op_t           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] rs,
        input logic             exm_we,
        input logic [REG_W-1:0] exm_rd,
        input logic             mwb_we,
        input logic [REG_W-1:0] mwb_rd
    );
        if (exm_we && exm_rd != REG_ZERO && exm_rd == rs)
            return FWD_EXM;
        else if (mwb_we && mwb_rd != REG_ZERO && mwb_rd == rs)
            return FWD_MWB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding selector for the two EX-stage source registers.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs1_i,
    input  logic [REG_W-1:0] ex_rs2_i,
    input  logic             exm_reg_write_i,
    input  logic [REG_W-1:0] exm_rd_i,
    input  logic             mwb_reg_write_i,
    input  logic [REG_W-1:0] mwb_rd_i,
    output fwd_sel_t         fwd_a_o,
    output fwd_sel_t         fwd_b_o
);

    logic [REG_W-1:0] rs_idx [2];
    fwd_sel_t         sel    [2];

    assign rs_idx[0] = ex_rs1_i;
    assign rs_idx[1] = ex_rs2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign sel[gi] = fwd_select(rs_idx[gi], exm_reg_write_i, exm_rd_i,
                                        mwb_reg_write_i, mwb_rd_i);
        end
    endgenerate

    assign fwd_a_o = sel[0];
    assign fwd_b_o = sel[1];

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with capture-time writeback bypass, load-use bubble
// insertion and EX-stage operand forwarding feeding the ALU.
module id_ex_operand_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int OPCODE_LENGTH = OPC_W,
    parameter int REG_ADDR_W    = REG_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alusrc,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     exm_reg_write,
    input  logic [REG_ADDR_W-1:0]    exm_rd,
    input  logic [DATA_WIDTH-1:0]    exm_result,
    input  logic                     mwb_reg_write,
    input  logic [REG_ADDR_W-1:0]    mwb_rd,
    input  logic [DATA_WIDTH-1:0]    mwb_result,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     hazard_stall,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write
);

    id_ex_t   ex_q, ex_d, capture;
    fwd_sel_t fwd_a, fwd_b;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // The register file is written this same cycle, so its read data may be stale.
    always_comb begin
        capture           = '0;
        capture.valid     = id_valid;
        capture.rs1       = id_rs1;
        capture.rs2       = id_rs2;
        capture.rd        = id_rd;
        capture.rs1_data  = (mwb_reg_write && mwb_rd != REG_ZERO && mwb_rd == id_rs1)
                            ? mwb_result : id_rs1_data;
        capture.rs2_data  = (mwb_reg_write && mwb_rd != REG_ZERO && mwb_rd == id_rs2)
                            ? mwb_result : id_rs2_data;
        capture.imm       = id_imm;
        capture.alusrc    = id_alusrc;
        capture.alu_op    = alu_op_t'(id_alu_op);
        capture.reg_write = id_reg_write;
        capture.mem_read  = id_mem_read;
        capture.mem_write = id_mem_write;
    end

    assign hazard_stall = ex_q.valid & ex_q.mem_read & id_valid & (ex_q.rd != REG_ZERO)
                        & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

    always_comb begin
        ex_d = capture;
        if (flush)
            ex_d = '0;
        else if (stall)
            ex_d = ex_q;
        else if (hazard_stall)
            ex_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    forward_unit u_forward_unit (
        .ex_rs1_i        (ex_q.rs1),
        .ex_rs2_i        (ex_q.rs2),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .mwb_reg_write_i (mwb_reg_write),
        .mwb_rd_i        (mwb_rd),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_EXM: SrcA = exm_result;
            FWD_MWB: SrcA = mwb_result;
            default: SrcA = ex_q.rs1_data;
        endcase
        case (fwd_b)
            FWD_EXM: fwd_rs2 = exm_result;
            FWD_MWB: fwd_rs2 = mwb_result;
            default: fwd_rs2 = ex_q.rs2_data;
        endcase
    end

    assign SrcB          = ex_q.alusrc ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = ex_q.valid;
    assign Operation     = ex_q.alu_op;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule
